emu_teclado: RTL

- Behavioural-synthesizable 4x4 matrix keypad emulator; the responder side of the column-scan keypad interface.
- Accepts 4-bit key codes through a valid/ready handshake into a small FIFO, then "presses" each key for a programmable time and releases it for a programmable gap.
- While pressed, answers the scanner's one-hot column drive with the matching one-hot row.
- Used on-chip for self-test and in benches in place of the physical keypad.

---
 rtl/emu_teclado.sv | 139 +++++++++++++
 1 files changed

// File: rtl/emu_teclado.sv
// 4x4 matrix keypad emulator: queues key codes, presses each for HOLD_CYC
// cycles, releases for GAP_CYC cycles, and answers the column scan with the
// matching row while a key is pressed.
module emu_teclado #(
  parameter int HOLD_CYC   = 8,
  parameter int GAP_CYC    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] tecla_in,
  input  logic       tecla_valid,
  output logic       tecla_ready,
  input  logic [3:0] col,
  output logic [3:0] fila,
  output logic [4:0] tecla_actual,
  output logic       fin_pulso,
  output logic       ocupado
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int MAXC = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYC - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [3:0]    key, key_nx;
  logic          fin_nx;

  logic [3:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;
  logic [3:0]    col_sel, row_sel;

  assign tecla_ready = (count != FULL_CNT);
  assign push        = tecla_valid && tecla_ready;
  assign ocupado     = (state != IDLE) || (count != '0);

  // FIFO storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tecla_in;
  end

  // FIFO pointers and occupancy; push and pop in the same edge cancel in count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // FSM state, key register, cycle counter and end-of-press pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      key       <= '0;
      fin_pulso <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      key       <= key_nx;
      fin_pulso <= fin_nx;
    end
  end

  // Next-state logic: pop on IDLE, count down PRESS then GAP
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    key_nx   = key;
    fin_nx   = 1'b0;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop      = 1'b1;
          key_nx   = mem[rd_ptr];
          cnt_nx   = HOLD_LD;
          state_nx = PRESS;
        end
      end
      PRESS: begin
        if (cnt == '0) begin
          fin_nx   = 1'b1;
          cnt_nx   = GAP_LD;
          state_nx = GAP;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      GAP: begin
        if (cnt == '0) state_nx = IDLE;
        else           cnt_nx   = cnt - 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Key code to one-hot (column, row) position on the pad
  always_comb begin
    col_sel = 4'b0000;
    row_sel = 4'b0000;
    case (key)
      4'h1: begin col_sel = 4'b0001; row_sel = 4'b0001; end
      4'h4: begin col_sel = 4'b0001; row_sel = 4'b0010; end
      4'h7: begin col_sel = 4'b0001; row_sel = 4'b0100; end
      4'hF: begin col_sel = 4'b0001; row_sel = 4'b1000; end
      4'h2: begin col_sel = 4'b0010; row_sel = 4'b0001; end
      4'h5: begin col_sel = 4'b0010; row_sel = 4'b0010; end
      4'h8: begin col_sel = 4'b0010; row_sel = 4'b0100; end
      4'h0: begin col_sel = 4'b0010; row_sel = 4'b1000; end
      4'h3: begin col_sel = 4'b0100; row_sel = 4'b0001; end
      4'h6: begin col_sel = 4'b0100; row_sel = 4'b0010; end
      4'h9: begin col_sel = 4'b0100; row_sel = 4'b0100; end
      4'hE: begin col_sel = 4'b0100; row_sel = 4'b1000; end
      4'hA: begin col_sel = 4'b1000; row_sel = 4'b0001; end
      4'hB: begin col_sel = 4'b1000; row_sel = 4'b0010; end
      4'hC: begin col_sel = 4'b1000; row_sel = 4'b0100; end
      default: begin col_sel = 4'b1000; row_sel = 4'b1000; end
    endcase
  end

  assign fila         = ((state == PRESS) && (col == col_sel)) ? row_sel : 4'b0000;
  assign tecla_actual = (state == PRESS) ? {1'b0, key} : 5'd16;

endmodule
